// File: rtl/arb_client.sv
// Requester-side controller for the r/g resource arbiter: takes a job, requests,
// owns the resource for job_len+1 cycles, then releases and enforces an idle gap.
module arb_client #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 8,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             r,
  input  logic             g,
  output logic             use_en,
  output logic             done,
  output logic             timeout_err,
  output logic             abort_err,
  output logic             grant_err
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TMO_MAX  = {TW{1'b1}};
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC);

  typedef enum logic [2:0] {IDLE, REQ, OWN, RELEASE, GAP} state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             gap_armed;

  function automatic logic [TW-1:0] sat_inc_tmo(input logic [TW-1:0] v);
    return (v == TMO_MAX) ? v : v + TW'(1);
  endfunction

  function automatic logic [GW-1:0] sat_dec_gap(input logic [GW-1:0] v);
    return (v == '0) ? v : v - GW'(1);
  endfunction

  function automatic logic [LEN_W-1:0] sat_dec_len(input logic [LEN_W-1:0] v);
    return (v == '0) ? v : v - LEN_W'(1);
  endfunction

  assign job_ready = (state == IDLE);
  assign use_en    = (state == OWN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      r           <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      abort_err   <= 1'b0;
      grant_err   <= 1'b0;
      cnt         <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      gap_armed   <= 1'b0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      abort_err   <= 1'b0;
      grant_err   <= 1'b0;
      case (state)
        // A grant seen while idle is flagged and blocks acceptance on that edge,
        // so a job never starts in the same cycle as an error pulse.
        IDLE: begin
          if (g) begin
            grant_err <= 1'b1;
          end else if (job_valid) begin
            cnt     <= job_len;
            r       <= 1'b1;
            tmo_cnt <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (g) begin
            state <= OWN;
          end else if (TIMEOUT > 0 && tmo_cnt >= TMO_LAST) begin
            r           <= 1'b0;
            timeout_err <= 1'b1;
            gap_cnt     <= GAP_LOAD;
            gap_armed   <= 1'b0;
            state       <= GAP;
          end else begin
            tmo_cnt <= sat_inc_tmo(tmo_cnt);
          end
        end
        OWN: begin
          if (!g) begin
            r         <= 1'b0;
            abort_err <= 1'b1;
            gap_cnt   <= GAP_LOAD;
            gap_armed <= 1'b0;
            state     <= GAP;
          end else if (cnt == '0) begin
            r     <= 1'b0;
            done  <= 1'b1;
            state <= RELEASE;
          end else begin
            cnt <= sat_dec_len(cnt);
          end
        end
        RELEASE: begin
          if (!g) begin
            if (GAP_CYC == 0) begin
              state <= IDLE;
            end else begin
              gap_cnt   <= GAP_LOAD;
              gap_armed <= 1'b1;
              state     <= GAP;
            end
          end
        end
        // After an error the arbiter may still be granting; counting starts at
        // the first edge that sees g low, and only later grants are spurious.
        GAP: begin
          if (g) begin
            if (gap_armed) grant_err <= 1'b1;
          end else begin
            gap_armed <= 1'b1;
            if (gap_cnt <= GW'(1)) state <= IDLE;
            else gap_cnt <= sat_dec_gap(gap_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
